// File: rtl/multicycle_divider.sv
// Multicycle restoring divider: one quotient bit per RUN cycle, MSB first, with
// signed/unsigned operation and a divide-by-zero flag. DivAns = {remainder, quotient}.
module multicycle_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [2*WIDTH-1:0]   DivAns
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic                 qneg_q, qneg_d;
  logic                 dneg_q, dneg_d;
  logic                 dz_q, dz_d;
  logic [2*WIDTH-1:0]   ans_q, ans_d;
  logic                 div_zero_q, div_zero_d;

  logic [WIDTH:0]       rem_shift;
  logic [WIDTH+1:0]     diff;
  logic                 q_bit;
  logic [WIDTH:0]       rem_step;
  logic [WIDTH-1:0]     quo_step;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    qneg_d     = qneg_q;
    dneg_d     = dneg_q;
    dz_d       = dz_q;
    ans_d      = ans_q;
    div_zero_d = div_zero_q;

    // quo_q starts as the dividend magnitude and is shifted out while quotient bits shift in.
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff      = {1'b0, rem_shift} - {2'b00, dvsr_q};
    q_bit     = ~diff[WIDTH+1];
    rem_step  = q_bit ? diff[WIDTH:0] : rem_shift;
    quo_step  = {quo_q[WIDTH-2:0], q_bit};
    quo_fix   = qneg_q ? -quo_step : quo_step;
    rem_fix   = dneg_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvsr_d  = b_mag;
          qneg_d  = a_neg ^ b_neg;
          dneg_d  = a_neg;
          dz_d    = (divisor == '0);
        end
      end
      RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d    = DONE;
          div_zero_d = dz_q;
          // With a zero divisor the remainder path reproduces the raw dividend bits.
          ans_d      = dz_q ? {rem_fix, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      qneg_q     <= 1'b0;
      dneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      ans_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      qneg_q     <= qneg_d;
      dneg_q     <= dneg_d;
      dz_q       <= dz_d;
      ans_q      <= ans_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = div_zero_q;
  assign DivAns   = ans_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider: directed cases plus randomized
// operands compared against an arithmetic reference model.
module tb_multicycle_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [63:0] DivAns;

  int vectors = 0;
  int miscompares = 0;

  multicycle_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero), .DivAns(DivAns)
  );

  always #5 clk = ~clk;

  // Reference: returns {div_zero, remainder, quotient}.
  function automatic logic [64:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [64:0] res;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    res = {1'b0, r[31:0], q[31:0]};
    return res;
  endfunction

  // Caller must be just after a negedge. Drives one divide and observes cycles 1..34.
  task automatic launch(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input int rst_at,
                        output int done_cnt, output int done_cyc, output int busy_bad,
                        output logic [63:0] ans, output logic dz,
                        output logic [63:0] hold_ans,
                        output logic post_busy, output logic [63:0] post_ans);
    done_cnt = 0; done_cyc = -1; busy_bad = 0;
    ans = 'x; dz = 1'bx; hold_ans = 'x; post_busy = 1'bx; post_ans = 'x;
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk);
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++; done_cyc = cyc; ans = DivAns; dz = div_zero;
      end
      if (rst_at == 0 && busy !== (cyc <= 33)) busy_bad++;
      if (rst_at != 0 && cyc > rst_at && busy !== 1'b0) busy_bad++;
      if (rst_at != 0 && cyc == rst_at + 1) begin
        post_busy = busy; post_ans = DivAns; reset = 1'b0;
      end
      if (cyc == 34) hold_ans = DivAns;
      if (rst_at != 0 && cyc == rst_at) begin
        reset = 1'b1; start = 1'b1;
      end else if (noise && cyc <= 33) begin
        start = 1'($urandom_range(0, 1));
        is_signed = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor = $urandom;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    vectors++; if (DivAns !== 64'd0) begin miscompares++; $display("FAIL reset_DivAns got %h want 0", DivAns); end
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_directed();
    int dc, dcyc, bb; logic [63:0] an, ha, pa; logic z, pb;
    logic [31:0] av [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'd40};
    logic [31:0] bv [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd41};
    bit          sv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] ev [6] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                            64'h00000005_FFFFFFFF, 64'h00000000_80000000, 64'h00000028_00000000};
    bit          zv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      launch(sv[i], av[i], bv[i], 1'b0, 0, dc, dcyc, bb, an, z, ha, pb, pa);
      vectors++; if (an !== ev[i]) begin miscompares++; $display("FAIL dir%0d_DivAns got %h want %h", i, an, ev[i]); end
      vectors++; if (z !== zv[i]) begin miscompares++; $display("FAIL dir%0d_div_zero got %b want %b", i, z, zv[i]); end
      vectors++; if (dc !== 1 || dcyc !== 33) begin miscompares++; $display("FAIL dir%0d_done count %0d cycle %0d want 1 at 33", i, dc, dcyc); end
      vectors++; if (bb !== 0) begin miscompares++; $display("FAIL dir%0d_busy bad cycles %0d want 0", i, bb); end
      vectors++; if (ha !== ev[i]) begin miscompares++; $display("FAIL dir%0d_hold got %h want %h", i, ha, ev[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int dc, dcyc, bb; logic [63:0] an, ha, pa; logic z, pb;
    launch(1'b0, 32'd100, 32'd7, 1'b1, 0, dc, dcyc, bb, an, z, ha, pb, pa);
    vectors++; if (an !== 64'h00000002_0000000E) begin miscompares++; $display("FAIL noise_DivAns got %h want 000000020000000e", an); end
    vectors++; if (dc !== 1 || dcyc !== 33) begin miscompares++; $display("FAIL noise_done count %0d cycle %0d want 1 at 33", dc, dcyc); end
    vectors++; if (bb !== 0) begin miscompares++; $display("FAIL noise_busy bad cycles %0d want 0", bb); end
    launch(1'b0, 32'd3, 32'd1, 1'b0, 0, dc, dcyc, bb, an, z, ha, pb, pa);
    vectors++; if (an !== 64'h00000000_00000003 || dc !== 1 || dcyc !== 33) begin
      miscompares++; $display("FAIL start34 got %h count %0d cycle %0d want 0000000000000003 1 at 33", an, dc, dcyc);
    end
  endtask

  task automatic test_reset_abort();
    int dc, dcyc, bb; logic [63:0] an, ha, pa; logic z, pb;
    launch(1'b0, 32'd100, 32'd7, 1'b0, 10, dc, dcyc, bb, an, z, ha, pb, pa);
    vectors++; if (dc !== 0) begin miscompares++; $display("FAIL abort_done count %0d want 0", dc); end
    vectors++; if (pb !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", pb); end
    vectors++; if (pa !== 64'd0) begin miscompares++; $display("FAIL abort_DivAns got %h want 0", pa); end
    vectors++; if (bb !== 0) begin miscompares++; $display("FAIL abort_busy_after bad cycles %0d want 0", bb); end
    launch(1'b0, 32'd20, 32'd3, 1'b0, 0, dc, dcyc, bb, an, z, ha, pb, pa);
    vectors++; if (an !== 64'h00000002_00000006 || dc !== 1 || dcyc !== 33) begin
      miscompares++; $display("FAIL after_abort got %h count %0d cycle %0d want 0000000200000006 1 at 33", an, dc, dcyc);
    end
  endtask

  task automatic test_back_to_back();
    int dc, dcyc, bb; logic [63:0] an, ha, pa; logic z, pb;
    launch(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, dc, dcyc, bb, an, z, ha, pb, pa);
    vectors++; if (an !== 64'h00000000_FFFFFFFF || dcyc !== 33 || dc !== 1) begin
      miscompares++; $display("FAIL b2b_first got %h cycle %0d count %0d want 00000000ffffffff at 33", an, dcyc, dc);
    end
    launch(1'b0, 32'd3, 32'h10, 1'b0, 0, dc, dcyc, bb, an, z, ha, pb, pa);
    vectors++; if (an !== 64'h00000003_00000000 || dcyc !== 33 || dc !== 1) begin
      miscompares++; $display("FAIL b2b_second got %h cycle %0d count %0d want 0000000300000000 at 33", an, dcyc, dc);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int dc, dcyc, bb; logic [63:0] an, ha, pa; logic z, pb;
    logic [31:0] a, b; bit s; logic [64:0] exp;
    for (int i = 0; i < 60; i++) begin
      a = pick(); b = pick(); s = 1'($urandom_range(0, 1));
      exp = model(s, a, b);
      launch(s, a, b, 1'b0, 0, dc, dcyc, bb, an, z, ha, pb, pa);
      vectors++; if (an !== exp[63:0] || z !== exp[64]) begin
        miscompares++; $display("FAIL rand%0d s=%0d %h/%h got %h z=%b want %h z=%b", i, s, a, b, an, z, exp[63:0], exp[64]);
      end
      vectors++; if (dc !== 1 || dcyc !== 33 || bb !== 0) begin
        miscompares++; $display("FAIL rand%0d_timing count %0d cycle %0d busybad %0d want 1 33 0", i, dc, dcyc, bb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_divider.md
MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the operand width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  request a divide; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement DIV, 0 = unsigned DIVU; captured with start.
REQ-007 dividend  input  WIDTH  numerator; captured with start.
REQ-008 divisor  input  WIDTH  denominator; captured with start.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle pulse marking that DivAns holds a new result.
REQ-011 div_zero  output  1  high with the result of a divide whose divisor was 0; held with DivAns.
REQ-012 DivAns  output  2*WIDTH  {remainder, quotient}: upper half goes to Hi, lower half goes to Lo.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 The block SHALL make these transitions:
- IDLE->RUN on a posedge with start=1.
- RUN->DONE after exactly WIDTH RUN cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-015 On the accepting edge, the block SHALL latch is_signed, the operand signs, and the operand magnitudes, and SHALL clear the iteration counter and the partial remainder.
- Magnitudes are absolute values when is_signed=1, raw values otherwise.
REQ-016 Each RUN cycle SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first.
- Each RUN cycle SHALL use a WIDTH+1-bit partial remainder so that no carry is lost.
REQ-017 On the final RUN edge, the block SHALL register DivAns and div_zero.
- Sign fix-up: the quotient is negated when is_signed=1 and the operand signs differ.
- Sign fix-up: the remainder is negated when is_signed=1 and the dividend was negative.
- Quotient truncates toward zero.
REQ-018 Latency SHALL be fixed: with start high in cycle 0, done SHALL be high in cycle WIDTH+1 (cycle 33 at default) and low in all other cycles.
REQ-019 DivAns and div_zero SHALL hold their values from done until the next done or reset.
REQ-020 start SHALL be ignored while busy=1, including in the DONE cycle; operand input changes while busy SHALL NOT affect the result.
REQ-021 A divisor of 0 SHALL keep the same latency and give quotient all ones, remainder = dividend (raw input bits), div_zero=1.
REQ-022 A signed divide of the most-negative value by -1 SHALL give quotient 0x80000000 and remainder 0, with no flag (default width).
REQ-023 A dividend smaller than the divisor SHALL give quotient 0 and remainder = dividend.

Reset
REQ-024 With reset=1 at a posedge, the block SHALL go to IDLE and clear the counter and partial remainder, and outputs SHALL read: busy=0, done=0, div_zero=0, DivAns=0.
REQ-025 A reset during RUN or DONE SHALL abort the operation with no done pulse; a start sampled in the same cycle as reset SHALL be ignored.

Verification
REQ-026 Unsigned 100/7, start high in cycle 0 -> done only in cycle 33, DivAns=0x00000002_0000000E, div_zero=0, busy high in cycles 1-33.
REQ-027 Signed -7/2 -> DivAns=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
REQ-028 Unsigned 5/0 -> DivAns=0x00000005_FFFFFFFF, div_zero=1, done still in cycle 33; signed 0x80000000/0xFFFFFFFF -> DivAns=0x00000000_80000000, div_zero=0.
REQ-029 Start pulses and operand changes in cycles 1-33 after an accepted 100/7 -> single done in cycle 33, result unchanged; a start in cycle 34 is accepted.
REQ-030 reset asserted in cycle 10 of a divide -> busy=0, DivAns=0 the next cycle, no done pulse; a new divide afterwards completes normally.
REQ-031 Back-to-back unsigned 0xFFFFFFFF/1 then 3/0x10 -> DivAns=0x00000000_FFFFFFFF, then 0x00000003_00000000, each with a 33-cycle latency.
